id_ex_hazard_controller: RTL and testbench
==========================================

// Module: id_ex_hazard_controller
// PURPOSE
//  Pipeline control end of the ID/EX register: generates its write-enable and
//  bubble-insert control, plus the PC and IF/ID enables/flush. Resolves
//  load-use stalls, taken-branch flushes and data-RAM wait states for the
//  5-stage core. Sits beside the decode stage; outputs feed PC, IF/ID and ID/EX.
// PARAMETERS
//  BRANCH_FLUSH_CYCLES  1  cycles of ID/EX bubbles after a redirect (>=1; covers instr-RAM read latency)
//  STALL_CNT_WIDTH      32 width of optional performance counters
// PORTS
//  clk              in   1   core clock, all state on posedge
//  reset            in   1   asynchronous, active-high reset
//  id_rs1_address   in   5   rs1 index of instruction in ID
//  id_rs2_address   in   5   rs2 index of instruction in ID
//  id_rs1_used      in   1   ID instruction reads rs1
//  id_rs2_used      in   1   ID instruction reads rs2
//  ex_rd_address    in   5   rd held in ID/EX register
//  ex_reg_wren      in   1   reg_wren held in ID/EX register
//  ex_load          in   1   ID/EX reg_write_data_src selects RAM data (load)
//  ex_branch_taken  in   1   EX resolved a PC redirect this cycle
//  mem_busy         in   1   data RAM not ready; whole pipe must freeze
//  pc_wren          out  1   PC register enable
//  if_id_wren       out  1   IF/ID register enable
//  if_id_flush      out  1   IF/ID loads a NOP this cycle
//  id_ex_wren       out  1   drives ID/EX wren
//  id_ex_bubble     out  1   decode forces in_reg_wren/in_ram_wren/in_next_pc_src to 0
//  stall_cycles     out  STALL_CNT_WIDTH  load-use stall count (STALL_COUNTER_EN only)
//  flush_cycles     out  STALL_CNT_WIDTH  bubble cycles from redirects (STALL_COUNTER_EN only)
// BEHAVIOUR
//  - State: RUN, FLUSH, MEM_WAIT; flush_cnt (clog2(BRANCH_FLUSH_CYCLES+1) bits).
//  - Outputs combinational from state + inputs; state registered.
//  - Reset asserted: state=RUN, flush_cnt=0, counters=0; outputs pc_wren=if_id_wren=id_ex_wren=0,
//    if_id_flush=1, id_ex_bubble=1. Reset mid-stall/flush aborts it; first cycle after release is RUN.
//  - Priority each cycle: mem_busy > branch/FLUSH > load-use > normal.
//  - mem_busy=1 (any state): all wren=0, flush=0, bubble=0; state->MEM_WAIT, flush_cnt held.
//    MEM_WAIT & !mem_busy: resume to FLUSH if flush_cnt!=0 else RUN, same cycle as normal decode.
//  - RUN & ex_branch_taken: pc_wren=1, if_id_wren=1, if_id_flush=1, id_ex_wren=1, bubble=1;
//    if BRANCH_FLUSH_CYCLES>1: flush_cnt<=BRANCH_FLUSH_CYCLES-1, ->FLUSH.
//  - FLUSH: same outputs as redirect but pc_wren=1 normally; flush_cnt--, ->RUN at 1.
//    ex_branch_taken and load-use ignored in FLUSH (EX holds bubbles).
//  - load-use = ex_load & ex_reg_wren & ex_rd_address!=0 &
//    ((id_rs1_used & rs1==rd) | (id_rs2_used & rs2==rd)): pc_wren=0, if_id_wren=0,
//    if_id_flush=0, id_ex_wren=1, bubble=1. Exactly one bubble per load-use (condition self-clears).
//  - Normal: pc_wren=if_id_wren=id_ex_wren=1, flush=0, bubble=0.
//  - x0 never hazards; rd match with id_rsN_used=0 never stalls.
// CONFIGURATION
//  STALL_COUNTER_EN defined: stall_cycles +1 per load-use cycle, flush_cycles +1 per bubble from
//   redirect/FLUSH; both wrap at 2^STALL_CNT_WIDTH, hold during mem_busy, cleared by reset.
//  Undefined: counter ports and logic absent; hazard behaviour identical.
// STRUCTURE
//  pipeline_ctrl_pkg: typedef enum logic [1:0] hazard_state_t {RUN,FLUSH,MEM_WAIT}; REG_ZERO=5'd0.
//  Single module; no sub-module (comparator + FSM + counters are small).
// TESTING
//  - ex_load=1,ex_reg_wren=1,rd=5, id rs1=5 used -> 1 cycle pc_wren=0,id_ex_wren=1,bubble=1, then normal.
//  - same but rd=0 or id_rs1_used=0 -> no stall; stall_cycles unchanged.
//  - BRANCH_FLUSH_CYCLES=3, ex_branch_taken 1 cycle -> 3 consecutive cycles bubble=1,if_id_flush=1.
//  - mem_busy=1 for 4 cycles during FLUSH (cnt=1) -> all wren=0 4 cycles, then 1 remaining flush cycle.
//  - mem_busy & load-use & branch simultaneous -> freeze only; after release branch wins over load-use.
//  - reset asserted mid-FLUSH asynchronously -> outputs go to reset values immediately; RUN after release.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM states and register constants.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    MEM_WAIT
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_hazard_controller.sv
// ID/EX hazard control: load-use stalls, redirect flushes, data-RAM freezes.
// Optional performance counters enabled by defining STALL_COUNTER_EN.
module id_ex_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int STALL_CNT_WIDTH     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1_address,
  input  logic [4:0] id_rs2_address,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd_address,
  input  logic       ex_reg_wren,
  input  logic       ex_load,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  output logic       pc_wren,
  output logic       if_id_wren,
  output logic       if_id_flush,
  output logic       id_ex_wren,
`ifdef STALL_COUNTER_EN
  output logic       id_ex_bubble,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles,
  output logic [STALL_CNT_WIDTH-1:0] flush_cycles
`else
  output logic       id_ex_bubble
`endif
);

  localparam int CW = $clog2(BRANCH_FLUSH_CYCLES + 1);

  hazard_state_t state, state_nx;
  logic [CW-1:0] flush_cnt, flush_cnt_nx;

  logic rs1_hit, rs2_hit, load_use;
  logic in_flush;
  logic sel_flush, sel_redir, sel_lu;

  assign rs1_hit = id_rs1_used && (id_rs1_address == ex_rd_address);
  assign rs2_hit = id_rs2_used && (id_rs2_address == ex_rd_address);

  assign load_use = ex_load && ex_reg_wren &&
                    (ex_rd_address != REG_ZERO) &&
                    (rs1_hit || rs2_hit);

  // A freeze leaves flush_cnt intact, so a non-zero count means a pending flush.
  assign in_flush = (state != RUN) && (flush_cnt != '0);

  assign sel_flush = !mem_busy && in_flush;
  assign sel_redir = !mem_busy && !in_flush && ex_branch_taken;
  assign sel_lu    = !mem_busy && !in_flush && !ex_branch_taken &&
                     load_use;

  always_comb begin
    pc_wren      = 1'b1;
    if_id_wren   = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_wren   = 1'b1;
    id_ex_bubble = 1'b0;
    state_nx     = RUN;
    flush_cnt_nx = flush_cnt;
    if (reset) begin
      pc_wren      = 1'b0;
      if_id_wren   = 1'b0;
      id_ex_wren   = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_wren    = 1'b0;
      if_id_wren = 1'b0;
      id_ex_wren = 1'b0;
      state_nx   = MEM_WAIT;
    end else if (sel_flush) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_cnt_nx = flush_cnt - 1'b1;
      state_nx     = (flush_cnt == CW'(1)) ? RUN : FLUSH;
    end else if (sel_redir) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_cnt_nx = CW'(BRANCH_FLUSH_CYCLES - 1);
      state_nx     = (BRANCH_FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (sel_lu) begin
      pc_wren      = 1'b0;
      if_id_wren   = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (sel_lu)
        stall_cycles <= stall_cycles + 1'b1;
      if (sel_flush || sel_redir)
        flush_cycles <= flush_cycles + 1'b1;
    end
  end
`else
  localparam int unused_cnt_width = STALL_CNT_WIDTH;
`endif

endmodule

// File: tb/tb_id_ex_hazard_controller.sv
// Directed + randomized bench for id_ex_hazard_controller against a
// bubble-budget reference model.
module tb_id_ex_hazard_controller;

  localparam int BFC = 3;
  localparam int W   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
  logic       id_rs1_used, id_rs2_used;
  logic       ex_reg_wren, ex_load, ex_branch_taken, mem_busy;
  logic       pc_wren, if_id_wren, if_id_flush;
  logic       id_ex_wren, id_ex_bubble;
`ifdef STALL_COUNTER_EN
  logic [W-1:0] stall_cycles, flush_cycles;
`endif

  always #5 clk = ~clk;

  id_ex_hazard_controller #(
    .BRANCH_FLUSH_CYCLES(BFC),
    .STALL_CNT_WIDTH(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs1_address(id_rs1_address),
    .id_rs2_address(id_rs2_address),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd_address(ex_rd_address),
    .ex_reg_wren(ex_reg_wren),
    .ex_load(ex_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy),
    .pc_wren(pc_wren),
    .if_id_wren(if_id_wren),
    .if_id_flush(if_id_flush),
    .id_ex_wren(id_ex_wren),
`ifdef STALL_COUNTER_EN
    .id_ex_bubble(id_ex_bubble),
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`else
    .id_ex_bubble(id_ex_bubble)
`endif
  );

  // Output vector order: {pc, if_id_wren, if_id_flush, id_ex_wren, bubble}
  localparam logic [4:0] O_RST  = 5'b00101;
  localparam logic [4:0] O_FRZ  = 5'b00000;
  localparam logic [4:0] O_RDIR = 5'b11111;
  localparam logic [4:0] O_LU   = 5'b00011;
  localparam logic [4:0] O_NRM  = 5'b11010;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // Model: bubbles still owed after a redirect, plus event counts.
  int           m_left = 0;
  logic [W-1:0] m_stall = '0;
  logic [W-1:0] m_flush = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {pc_wren, if_id_wren, if_id_flush, id_ex_wren, id_ex_bubble};
  endfunction

  task automatic cyc(input string tag);
    logic       lu;
    logic [4:0] exp;
    @(negedge clk);
    lu = ex_load && ex_reg_wren && (ex_rd_address != 0) &&
         ((id_rs1_used && id_rs1_address == ex_rd_address) ||
          (id_rs2_used && id_rs2_address == ex_rd_address));
`ifdef STALL_COUNTER_EN
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(m_stall));
    chk({tag, "_flush"}, 32'(flush_cycles), 32'(m_flush));
`endif
    if (reset) begin
      exp = O_RST;
      m_left = 0;
      m_stall = '0;
      m_flush = '0;
    end else if (mem_busy) begin
      exp = O_FRZ;
    end else if (m_left > 0) begin
      exp = O_RDIR;
      m_left--;
      m_flush++;
    end else if (ex_branch_taken) begin
      exp = O_RDIR;
      m_left = BFC - 1;
      m_flush++;
    end else if (lu) begin
      exp = O_LU;
      m_stall++;
    end else begin
      exp = O_NRM;
    end
    chk(tag, 32'(outs()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic on, input logic [4:0] rd,
                        input logic used);
    ex_load        = on;
    ex_reg_wren    = on;
    ex_rd_address  = rd;
    id_rs1_address = 5'd5;
    id_rs1_used    = used;
  endtask

  initial begin
    reset           = 1'b1;
    id_rs1_address  = '0;
    id_rs2_address  = '0;
    id_rs1_used     = 1'b0;
    id_rs2_used     = 1'b0;
    ex_rd_address   = '0;
    ex_reg_wren     = 1'b0;
    ex_load         = 1'b0;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
    #2;
    chk("reset_out", 32'(outs()), 32'(O_RST));
    cyc("reset_cyc");
    reset = 1'b0;
    cyc("run_idle");

    // Load-use: one bubble, then normal once the load moves on.
    set_lu(1'b1, 5'd5, 1'b1);
    cyc("lu_stall");
    set_lu(1'b0, 5'd0, 1'b0);
    cyc("lu_after");
    set_lu(1'b1, 5'd0, 1'b1);
    id_rs1_address = 5'd0;
    cyc("lu_x0");
    set_lu(1'b1, 5'd5, 1'b0);
    cyc("lu_unused");
    ex_load = 1'b0;
    ex_reg_wren = 1'b0;
    id_rs2_used = 1'b1;
    id_rs2_address = 5'd7;
    ex_load = 1'b1;
    ex_reg_wren = 1'b1;
    ex_rd_address = 5'd7;
    cyc("lu_rs2");
    set_lu(1'b0, 5'd0, 1'b0);
    id_rs2_used = 1'b0;

    // Redirect: BFC consecutive bubbles; branch/load-use ignored in flush.
    ex_branch_taken = 1'b1;
    cyc("br_0");
    set_lu(1'b1, 5'd5, 1'b1);
    cyc("br_1");
    ex_branch_taken = 1'b0;
    cyc("br_2");
    cyc("br_done_lu");
    set_lu(1'b0, 5'd0, 1'b0);
    cyc("br_normal");

    // Freeze during flush with one bubble left.
    ex_branch_taken = 1'b1;
    cyc("fz_br");
    ex_branch_taken = 1'b0;
    cyc("fz_fl1");
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc("fz_busy");
    mem_busy = 1'b0;
    cyc("fz_resume");
    cyc("fz_normal");

    // Simultaneous freeze + load-use + branch; branch wins after release.
    mem_busy = 1'b1;
    ex_branch_taken = 1'b1;
    set_lu(1'b1, 5'd5, 1'b1);
    cyc("sim_busy0");
    cyc("sim_busy1");
    mem_busy = 1'b0;
    cyc("sim_branch");
    ex_branch_taken = 1'b0;
    cyc("sim_fl1");
    cyc("sim_fl2");
    cyc("sim_lu");
    set_lu(1'b0, 5'd0, 1'b0);
    cyc("sim_normal");

    // Asynchronous reset in the middle of a flush.
    ex_branch_taken = 1'b1;
    cyc("ar_br");
    ex_branch_taken = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_immediate", 32'(outs()), 32'(O_RST));
    cyc("ar_hold");
    reset = 1'b0;
    cyc("ar_run");

    // Randomized traffic over a small register window to force matches.
    for (int i = 0; i < 400; i++) begin
      id_rs1_address  = 5'($urandom_range(0, 3));
      id_rs2_address  = 5'($urandom_range(0, 3));
      ex_rd_address   = 5'($urandom_range(0, 3));
      id_rs1_used     = 1'($urandom);
      id_rs2_used     = 1'($urandom);
      ex_reg_wren     = 1'($urandom);
      ex_load         = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy        = ($urandom_range(0, 5) == 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
